calc_sequencer: RTL and testbench

- Central controller for the calculator datapath.
- Accepts decoded key events from the keypad scanner.
- Emits one-cycle strobes (newhex/hexcode, newop, eq, BS) to the operand register block.
- Holds the pending operator and runs the multi-cycle arithmetic unit over a start/done handshake.
- Enforces the digit-entry limit and the error/clear policy.

---
 rtl/calc_pkg.sv | 38 +++
 rtl/calc_sequencer_if.sv | 34 +++
 rtl/calc_key_decode.sv | 35 +++
 rtl/calc_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, operator encoding and controller states for the calculator sequencer.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'd16;
  localparam logic [4:0] KEY_SUB = 5'd17;
  localparam logic [4:0] KEY_MUL = 5'd18;
  localparam logic [4:0] KEY_EQ  = 5'd19;
  localparam logic [4:0] KEY_BS  = 5'd20;
  localparam logic [4:0] KEY_CLR = 5'd21;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ALU_WAIT = 3'd1,
    S_EQ_OUT   = 3'd2,
    S_OP_OUT   = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  // Map an operator key to its ALU encoding; anything else yields OP_NONE.
  function automatic op_t key_to_op(input logic [4:0] code);
    op_t op;
    case (code)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Key, ALU and register-strobe signals of the calculator sequencer.
// master is the sequencer side; slave is the keypad/ALU/register side.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic       alu_start;
  op_t        alu_op;
  logic       alu_done;
  logic       alu_ovf;
  logic       newhex;
  logic [3:0] hexcode;
  logic       newop;
  logic       eq;
  logic       BS;
  logic       clr;
  op_t        op_pending;
  logic [2:0] digit_count;
  logic       error;

  modport master (
    input  key_valid, key_code, alu_done, alu_ovf,
    output key_ready, alu_start, alu_op, newhex, hexcode, newop, eq, BS, clr,
           op_pending, digit_count, error
  );

  modport slave (
    output key_valid, key_code, alu_done, alu_ovf,
    input  key_ready, alu_start, alu_op, newhex, hexcode, newop, eq, BS, clr,
           op_pending, digit_count, error
  );
endinterface

// File: rtl/calc_key_decode.sv
// Pure combinational classifier of a 5-bit key code into key classes.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic [4:0] key_code,
  output logic       is_hex,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_bs,
  output logic       is_clr,
  output op_t        op
);

  // Codes 22-31 leave every class flag low so they fall through as no-ops.
  always_comb begin
    is_hex = 1'b0;
    is_op  = 1'b0;
    is_eq  = 1'b0;
    is_bs  = 1'b0;
    is_clr = 1'b0;
    op     = key_to_op(key_code);
    if (key_code[4] == 1'b0) begin
      is_hex = 1'b1;
    end else begin
      case (key_code)
        KEY_ADD, KEY_SUB, KEY_MUL: is_op  = 1'b1;
        KEY_EQ:                    is_eq  = 1'b1;
        KEY_BS:                    is_bs  = 1'b1;
        KEY_CLR:                   is_clr = 1'b1;
        default:                   is_hex = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: turns key events into register strobes, runs the ALU
// handshake for pending operators, and owns the digit limit and error/clear policy.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 16
) (
  input logic              clock,
  input logic              reset,
  calc_sequencer_if.master bus
);

  localparam int              TW           = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [2:0]      MAX_CNT      = 3'(MAX_DIGITS);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(ALU_TIMEOUT - 1);

  logic    is_hex_s;
  logic    is_op_s;
  logic    is_eq_s;
  logic    is_bs_s;
  logic    is_clr_s;
  op_t     key_op_s;
  logic    clr_req_s;
  logic    idle_key_s;
  logic    start_s;

  state_t  state_r;
  state_t  state_nxt_s;

  logic          newhex_r,      newhex_nxt_s;
  logic [3:0]    hexcode_r,     hexcode_nxt_s;
  logic          newop_r,       newop_nxt_s;
  logic          eq_r,          eq_nxt_s;
  logic          bs_r,          bs_nxt_s;
  logic          clr_r,         clr_nxt_s;
  logic          alu_start_r,   alu_start_nxt_s;
  op_t           alu_op_r,      alu_op_nxt_s;
  op_t           op_pending_r,  op_pending_nxt_s;
  op_t           latch_op_r,    latch_op_nxt_s;
  logic          chain_r,       chain_nxt_s;
  logic [2:0]    digit_count_r, digit_count_nxt_s;
  logic          error_r,       error_nxt_s;
  logic [TW-1:0] timeout_r,     timeout_nxt_s;

  calc_key_decode u_key_decode (
    .key_code (bus.key_code),
    .is_hex   (is_hex_s),
    .is_op    (is_op_s),
    .is_eq    (is_eq_s),
    .is_bs    (is_bs_s),
    .is_clr   (is_clr_s),
    .op       (key_op_s)
  );

  // CLR bypasses key_ready; every other key is only taken in IDLE.
  assign clr_req_s  = bus.key_valid && is_clr_s;
  assign idle_key_s = bus.key_valid && (state_r == S_IDLE);
  assign start_s    = idle_key_s && (op_pending_r != OP_NONE) &&
                      (is_eq_s || (is_op_s && (digit_count_r != 3'd0)));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (clr_req_s) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_nxt_s = S_ALU_WAIT;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_ALU_WAIT: begin
          if (bus.alu_done) begin
            state_nxt_s = bus.alu_ovf ? S_ERROR : S_EQ_OUT;
          end else if (timeout_r == TIMEOUT_LAST) begin
            state_nxt_s = S_ERROR;
          end else begin
            state_nxt_s = S_ALU_WAIT;
          end
        end
        S_EQ_OUT: state_nxt_s = chain_r ? S_OP_OUT : S_IDLE;
        S_OP_OUT: state_nxt_s = S_IDLE;
        S_ERROR:  state_nxt_s = S_ERROR;
        default:  state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Output logic: next values of every strobe and datapath register.
  always_comb begin
    newhex_nxt_s      = 1'b0;
    newop_nxt_s       = 1'b0;
    eq_nxt_s          = 1'b0;
    bs_nxt_s          = 1'b0;
    clr_nxt_s         = 1'b0;
    alu_start_nxt_s   = 1'b0;
    hexcode_nxt_s     = hexcode_r;
    alu_op_nxt_s      = alu_op_r;
    op_pending_nxt_s  = op_pending_r;
    latch_op_nxt_s    = latch_op_r;
    chain_nxt_s       = chain_r;
    digit_count_nxt_s = digit_count_r;
    error_nxt_s       = error_r;
    timeout_nxt_s     = timeout_r;
    if (clr_req_s) begin
      clr_nxt_s         = 1'b1;
      alu_op_nxt_s      = OP_NONE;
      op_pending_nxt_s  = OP_NONE;
      latch_op_nxt_s    = OP_NONE;
      chain_nxt_s       = 1'b0;
      digit_count_nxt_s = 3'd0;
      error_nxt_s       = 1'b0;
      timeout_nxt_s     = '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            // An operator key here chains: the new op waits until the result is loaded.
            alu_start_nxt_s = 1'b1;
            alu_op_nxt_s    = op_pending_r;
            chain_nxt_s     = is_op_s;
            latch_op_nxt_s  = key_op_s;
            timeout_nxt_s   = '0;
          end else if (idle_key_s && is_hex_s) begin
            if (digit_count_r < MAX_CNT) begin
              newhex_nxt_s      = 1'b1;
              hexcode_nxt_s     = bus.key_code[3:0];
              digit_count_nxt_s = digit_count_r + 3'd1;
            end else begin
              newhex_nxt_s = 1'b0;
            end
          end else if (idle_key_s && is_bs_s) begin
            if (digit_count_r != 3'd0) begin
              bs_nxt_s          = 1'b1;
              digit_count_nxt_s = digit_count_r - 3'd1;
            end else begin
              bs_nxt_s = 1'b0;
            end
          end else if (idle_key_s && is_op_s) begin
            newop_nxt_s       = 1'b1;
            op_pending_nxt_s  = key_op_s;
            digit_count_nxt_s = 3'd0;
          end else begin
            newhex_nxt_s = 1'b0;
          end
        end
        S_ALU_WAIT: begin
          if (bus.alu_done) begin
            alu_op_nxt_s = OP_NONE;
            if (bus.alu_ovf) begin
              error_nxt_s = 1'b1;
            end else begin
              eq_nxt_s          = 1'b1;
              digit_count_nxt_s = 3'd0;
            end
          end else if (timeout_r == TIMEOUT_LAST) begin
            alu_op_nxt_s = OP_NONE;
            error_nxt_s  = 1'b1;
          end else begin
            timeout_nxt_s = timeout_r + TW'(1);
          end
        end
        S_EQ_OUT: begin
          if (chain_r) begin
            newop_nxt_s      = 1'b1;
            op_pending_nxt_s = latch_op_r;
            chain_nxt_s      = 1'b0;
          end else begin
            op_pending_nxt_s = OP_NONE;
          end
        end
        S_OP_OUT: newop_nxt_s = 1'b0;
        S_ERROR:  error_nxt_s = 1'b1;
        default:  error_nxt_s = error_r;
      endcase
    end
  end

  // Strobe and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      newhex_r      <= 1'b0;
      hexcode_r     <= 4'd0;
      newop_r       <= 1'b0;
      eq_r          <= 1'b0;
      bs_r          <= 1'b0;
      clr_r         <= 1'b0;
      alu_start_r   <= 1'b0;
      alu_op_r      <= OP_NONE;
      op_pending_r  <= OP_NONE;
      latch_op_r    <= OP_NONE;
      chain_r       <= 1'b0;
      digit_count_r <= 3'd0;
      error_r       <= 1'b0;
      timeout_r     <= '0;
    end else begin
      newhex_r      <= newhex_nxt_s;
      hexcode_r     <= hexcode_nxt_s;
      newop_r       <= newop_nxt_s;
      eq_r          <= eq_nxt_s;
      bs_r          <= bs_nxt_s;
      clr_r         <= clr_nxt_s;
      alu_start_r   <= alu_start_nxt_s;
      alu_op_r      <= alu_op_nxt_s;
      op_pending_r  <= op_pending_nxt_s;
      latch_op_r    <= latch_op_nxt_s;
      chain_r       <= chain_nxt_s;
      digit_count_r <= digit_count_nxt_s;
      error_r       <= error_nxt_s;
      timeout_r     <= timeout_nxt_s;
    end
  end

  assign bus.key_ready   = (state_r == S_IDLE) || ((state_r == S_ERROR) && is_clr_s);
  assign bus.newhex      = newhex_r;
  assign bus.hexcode     = hexcode_r;
  assign bus.newop       = newop_r;
  assign bus.eq          = eq_r;
  assign bus.BS          = bs_r;
  assign bus.clr         = clr_r;
  assign bus.alu_start   = alu_start_r;
  assign bus.alu_op      = alu_op_r;
  assign bus.op_pending  = op_pending_r;
  assign bus.digit_count = digit_count_r;
  assign bus.error       = error_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: hand-computed expectations for digit entry,
// plain and chained ALU operations, overflow, timeout, backspace and clear.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_newhex = 0, n_newop = 0, n_eq = 0, n_bs = 0, n_start = 0, n_overlap = 0;

  calc_sequencer_if bus();

  calc_sequencer #(.MAX_DIGITS(4), .ALU_TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Strobe pulse counters, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.newhex)           n_newhex  <= n_newhex + 1;
      if (bus.newop)            n_newop   <= n_newop + 1;
      if (bus.eq)               n_eq      <= n_eq + 1;
      if (bus.BS)               n_bs      <= n_bs + 1;
      if (bus.alu_start)        n_start   <= n_start + 1;
      if (bus.eq && bus.newop)  n_overlap <= n_overlap + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic press(input logic [4:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic alu_finish(input int wait_cycles, input logic ovf);
    repeat (wait_cycles) tick();
    bus.alu_done = 1'b1;
    bus.alu_ovf  = ovf;
    tick();
    bus.alu_done = 1'b0;
    bus.alu_ovf  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_hex, b_newop, b_eq, b_bs, b_start;
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    bus.alu_done  = 1'b0;
    bus.alu_ovf   = 1'b0;
    repeat (3) tick();

    check_val("rst_key_ready", 32'(bus.key_ready), 32'd1);
    check_val("rst_strobes", {26'd0, bus.newhex, bus.newop, bus.eq, bus.BS, bus.clr, bus.alu_start}, 32'd0);
    check_val("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check_val("rst_op_pending", 32'(bus.op_pending), 32'd0);
    check_val("rst_digit_count", 32'(bus.digit_count), 32'd0);
    check_val("rst_error", 32'(bus.error), 32'd0);
    reset = 1'b0;
    tick();

    // Digit limit: four accepted, fifth dropped.
    b_hex = n_newhex;
    for (int k = 1; k <= 4; k++) begin
      press(5'(k));
      check_val("t1_newhex", 32'(bus.newhex), 32'd1);
      check_val("t1_hexcode", 32'(bus.hexcode), 32'(k));
    end
    press(5'd5);
    check_val("t1_fifth_dropped", 32'(bus.newhex), 32'd0);
    check_val("t1_digit_count", 32'(bus.digit_count), 32'd4);
    check_val("t1_newhex_total", 32'(n_newhex - b_hex), 32'd4);
    press(KEY_CLR);
    check_val("t1_clr", 32'(bus.clr), 32'd1);
    check_val("t1_clr_digits", 32'(bus.digit_count), 32'd0);
    tick();
    check_val("t1_clr_width", 32'(bus.clr), 32'd0);

    // 1 + 2 = : ALU done three cycles after start.
    b_start = n_start;
    press(5'd1);
    press(KEY_ADD);
    check_val("t2_newop", 32'(bus.newop), 32'd1);
    check_val("t2_op_pending_add", 32'(bus.op_pending), 32'd1);
    check_val("t2_digits_after_op", 32'(bus.digit_count), 32'd0);
    press(5'd2);
    press(KEY_EQ);
    check_val("t2_alu_start", 32'(bus.alu_start), 32'd1);
    check_val("t2_alu_op", 32'(bus.alu_op), 32'd1);
    check_val("t2_key_ready_wait", 32'(bus.key_ready), 32'd0);
    tick();
    check_val("t2_alu_start_width", 32'(bus.alu_start), 32'd0);
    check_val("t2_alu_op_held", 32'(bus.alu_op), 32'd1);
    alu_finish(2, 1'b0);
    check_val("t2_eq", 32'(bus.eq), 32'd1);
    check_val("t2_eq_digits", 32'(bus.digit_count), 32'd0);
    tick();
    check_val("t2_eq_width", 32'(bus.eq), 32'd0);
    check_val("t2_op_pending_none", 32'(bus.op_pending), 32'd0);
    check_val("t2_key_ready_idle", 32'(bus.key_ready), 32'd1);
    check_val("t2_start_count", 32'(n_start - b_start), 32'd1);

    // 3 + 4 * : chained operator gives eq then newop.
    press(5'd3);
    press(KEY_ADD);
    press(5'd4);
    b_hex   = n_newhex;
    b_newop = n_newop;
    press(KEY_MUL);
    check_val("t3_alu_start", 32'(bus.alu_start), 32'd1);
    check_val("t3_alu_op", 32'(bus.alu_op), 32'd1);
    check_val("t3_no_newop_yet", 32'(bus.newop), 32'd0);
    alu_finish(2, 1'b0);
    check_val("t3_eq", 32'(bus.eq), 32'd1);
    check_val("t3_newop_not_with_eq", 32'(bus.newop), 32'd0);
    tick();
    check_val("t3_eq_done", 32'(bus.eq), 32'd0);
    check_val("t3_newop", 32'(bus.newop), 32'd1);
    check_val("t3_op_pending_mul", 32'(bus.op_pending), 32'd3);
    tick();
    check_val("t3_idle", 32'(bus.key_ready), 32'd1);
    check_val("t3_newop_count", 32'(n_newop - b_newop), 32'd1);
    check_val("t3_no_newhex", 32'(n_newhex - b_hex), 32'd0);
    check_val("t3_no_overlap", 32'(n_overlap), 32'd0);

    // 7 * 9 = with overflow: sticky error until CLR.
    press(KEY_CLR);
    press(5'd7);
    press(KEY_MUL);
    check_val("t4_op_pending_mul", 32'(bus.op_pending), 32'd3);
    press(5'd9);
    press(KEY_EQ);
    check_val("t4_alu_op", 32'(bus.alu_op), 32'd3);
    alu_finish(1, 1'b1);
    check_val("t4_error", 32'(bus.error), 32'd1);
    check_val("t4_no_eq", 32'(bus.eq), 32'd0);
    check_val("t4_key_ready_err", 32'(bus.key_ready), 32'd0);
    b_hex   = n_newhex;
    b_eq    = n_eq;
    b_bs    = n_bs;
    b_start = n_start;
    press(5'd5);
    press(KEY_EQ);
    press(KEY_BS);
    check_val("t4_err_no_strobes", 32'((n_newhex - b_hex) + (n_eq - b_eq) + (n_bs - b_bs) + (n_start - b_start)), 32'd0);
    check_val("t4_error_sticky", 32'(bus.error), 32'd1);
    bus.key_code = KEY_CLR;
    #1;
    check_val("t4_key_ready_clr", 32'(bus.key_ready), 32'd1);
    press(KEY_CLR);
    check_val("t4_clr", 32'(bus.clr), 32'd1);
    check_val("t4_error_cleared", 32'(bus.error), 32'd0);
    check_val("t4_op_pending_cleared", 32'(bus.op_pending), 32'd0);

    // 1 + 1 = with no done: error exactly 16 cycles after alu_start.
    press(5'd1);
    press(KEY_ADD);
    press(5'd1);
    press(KEY_EQ);
    check_val("t5_alu_start", 32'(bus.alu_start), 32'd1);
    repeat (15) tick();
    check_val("t5_no_error_at_15", 32'(bus.error), 32'd0);
    tick();
    check_val("t5_error_at_16", 32'(bus.error), 32'd1);
    press(KEY_CLR);
    check_val("t5_clr_error", 32'(bus.error), 32'd0);

    // Backspace boundaries, operator replacement, CLR mid-wait with a late done.
    b_bs = n_bs;
    press(KEY_BS);
    check_val("t6_bs_empty", 32'(bus.BS), 32'd0);
    check_val("t6_bs_empty_count", 32'(n_bs - b_bs), 32'd0);
    press(5'd5);
    press(KEY_BS);
    check_val("t6_bs", 32'(bus.BS), 32'd1);
    check_val("t6_bs_digits", 32'(bus.digit_count), 32'd0);
    press(KEY_ADD);
    press(KEY_SUB);
    check_val("t6_replace_newop", 32'(bus.newop), 32'd1);
    check_val("t6_replace_op", 32'(bus.op_pending), 32'd2);
    check_val("t6_replace_no_start", 32'(bus.alu_start), 32'd0);
    press(5'd3);
    press(KEY_EQ);
    check_val("t6_alu_op_sub", 32'(bus.alu_op), 32'd2);
    tick();
    b_hex = n_newhex;
    press(5'd6);
    check_val("t6_wait_key_dropped", 32'(n_newhex - b_hex), 32'd0);
    press(KEY_CLR);
    check_val("t6_clr_wait", 32'(bus.clr), 32'd1);
    check_val("t6_clr_idle", 32'(bus.key_ready), 32'd1);
    check_val("t6_clr_op_none", 32'(bus.op_pending), 32'd0);
    b_eq = n_eq;
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
    check_val("t6_late_done_no_eq", 32'(bus.eq), 32'd0);
    tick();
    check_val("t6_late_done_eq_count", 32'(n_eq - b_eq), 32'd0);
    check_val("t6_late_done_idle", 32'(bus.key_ready), 32'd1);
    check_val("t6_late_done_no_error", 32'(bus.error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
